imem_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 20 ++
 rtl/byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

   localparam int unsigned IMEM_AW_DEF    = 10;
   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam int unsigned HDR_W          = HDR_BYTES * BYTE_W;

   typedef enum logic [2:0] {
      HDR_LO = 3'd0,
      HDR_HI = 3'd1,
      DATA   = 3'd2,
      FLUSH  = 3'd3,
      RUN    = 3'd4,
      ERR    = 3'd5
   } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// 8->32 little-endian packer: first byte of a word lands in bits 7:0.
module byte_packer
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word_c,
   output logic              word_valid_c
);

   localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   // Shift right so that after four bytes the oldest sits in the low lane.
   always_comb begin
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      word_c       = {byte_in, shreg_q[WORD_W-1:BYTE_W]};
      word_valid_c = 1'b0;
      if (clear) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (byte_valid) begin
         shreg_d      = word_c;
         word_valid_c = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
         cnt_d        = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header + little-endian payload stream into IMEM, then releases the core.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned IMEM_AW   = IMEM_AW_DEF,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BYTE_W-1:0]  rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [WORD_W-1:0]  imem_wdata,
   output logic               imem_wren,
   output logic               core_reset,
   output logic               done,
   output logic               error
);

   ld_state_e          state_q,      state_d;
   logic [BYTE_W-1:0]  hdr_lo_q,     hdr_lo_d;
   logic [HDR_W-1:0]   nwords_q,     nwords_d;
   logic [IMEM_AW-1:0] idx_q,        idx_d;
   logic [IMEM_AW-1:0] addr_q,       addr_d;
   logic [WORD_W-1:0]  wdata_q,      wdata_d;
   logic               wren_q,       wren_d;
   logic               core_reset_q, core_reset_d;
   logic               done_q,       done_d;
   logic               error_q,      error_d;

   logic               accept_c;
   logic               pk_clear_c;
   logic               pk_valid_c;
   logic [WORD_W-1:0]  pk_word_c;
   logic               pk_word_valid_c;
   logic [HDR_W-1:0]   hdr_c;

   // Ready only in the receiving states, and never while reset is held.
   assign rx_ready   = reset && ((state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA));
   assign accept_c   = rx_valid && rx_ready;
   assign pk_clear_c = accept_c && (state_q == HDR_HI);
   assign pk_valid_c = accept_c && (state_q == DATA);
   assign hdr_c      = {rx_data, hdr_lo_q};

   byte_packer u_packer (
      .clk          (clk),
      .rst_n        (reset),
      .clear        (pk_clear_c),
      .byte_valid   (pk_valid_c),
      .byte_in      (rx_data),
      .word_c       (pk_word_c),
      .word_valid_c (pk_word_valid_c)
   );

   always_comb begin
      state_d  = state_q;
      hdr_lo_d = hdr_lo_q;
      nwords_d = nwords_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wren_d   = 1'b0;
      case (state_q)
         HDR_LO: begin
            if (accept_c) begin
               hdr_lo_d = rx_data;
               state_d  = HDR_HI;
            end
         end
         HDR_HI: begin
            if (accept_c) begin
               nwords_d = hdr_c;
               if (hdr_c == '0) begin
                  state_d = RUN;
               end else if (32'(hdr_c) > 32'(MAX_WORDS)) begin
                  state_d = ERR;
               end else begin
                  idx_d   = '0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (pk_word_valid_c) begin
               wren_d  = 1'b1;
               addr_d  = idx_q;
               wdata_d = pk_word_c;
               idx_d   = idx_q + IMEM_AW'(1);
               if ((32'(idx_q) + 32'd1) == 32'(nwords_q)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH:   state_d = RUN;
         RUN:     state_d = RUN;
         ERR:     state_d = ERR;
         default: state_d = HDR_LO;
      endcase
      // Status follows the state being entered so it lines up with the transition edge.
      core_reset_d = (state_d == RUN);
      done_d       = (state_d == RUN);
      error_d      = (state_d == ERR);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= HDR_LO;
         hdr_lo_q     <= '0;
         nwords_q     <= '0;
         idx_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wren_q       <= 1'b0;
         core_reset_q <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_lo_q     <= hdr_lo_d;
         nwords_q     <= nwords_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wren_q       <= wren_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign imem_wren  = wren_q;
   assign core_reset = core_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes queued by the driver, checked by a monitor.
module tb_imem_loader;

   localparam int AW    = 10;
   localparam int MAXW  = 1024;

   logic          clk;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          imem_wren;
   logic          core_reset;
   logic          done;
   logic          error;

   imem_loader #(.IMEM_AW(AW), .MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .imem_wren  (imem_wren),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   typedef struct {
      int          addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] img       [0:MAXW-1];
   logic [31:0] mem_model [0:MAXW-1];
   int          n_cmp  = 0;
   int          n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the next queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (imem_wren === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_wren: addr %h data %h with empty scoreboard", imem_addr, imem_wdata);
            end else begin
               e = sb_q.pop_front();
               check("wr_addr", 32'(imem_addr), 32'(e.addr));
               check("wr_data", imem_wdata, e.data);
            end
            mem_model[imem_addr] = imem_wdata;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b0;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_core_reset", 32'(core_reset), 32'd0);
      check("rst_rx_ready",   32'(rx_ready),   32'd0);
      check("rst_wren",       32'(imem_wren),  32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_error",      32'(error),      32'd0);
      reset = 1'b1;
      #1;
      check("rst_rel_ready",  32'(rx_ready),   32'd1);
   endtask

   // Present a byte after an idle gap and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int budget;
      budget = 200;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: byte %h never accepted", b);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Reference: header N then words little-endian; each complete word is one write at its index.
   task automatic load(input int n, input int max_gap, input int abort_after);
      logic [15:0] hdr;
      logic [31:0] word;
      int          nsend;
      hdr   = 16'(n);
      nsend = (abort_after >= 0) ? abort_after : 4 * n;
      for (int i = 0; i < n; i++) mem_model[i] = 'x;
      for (int w = 0; w < n; w++)
         if (abort_after < 0 || 4 * (w + 1) <= abort_after) sb_q.push_back('{w, img[w]});
      send_byte(hdr[7:0],  $urandom_range(0, max_gap));
      send_byte(hdr[15:8], $urandom_range(0, max_gap));
      for (int b = 0; b < nsend; b++) begin
         word = img[b / 4];
         send_byte(8'(word >> (8 * (b % 4))), $urandom_range(0, max_gap));
      end
      if (abort_after >= 0) begin
         @(negedge clk);
         check("abort_sb_drain", 32'(sb_q.size()), 32'd0);
         check("abort_done",     32'(done),        32'd0);
         return;
      end
      if (n != 0) begin
         @(negedge clk);
         check("flush_wren",       32'(imem_wren),  32'd1);
         check("flush_core_reset", 32'(core_reset), 32'd0);
      end
      @(negedge clk);
      check("release_core_reset", 32'(core_reset), 32'd1);
      check("release_done",       32'(done),       32'd1);
      check("release_ready",      32'(rx_ready),   32'd0);
      check("sb_drain",           32'(sb_q.size()), 32'd0);
      for (int i = 0; i < n; i++) check("readback", mem_model[i], img[i]);
   endtask

   task automatic random_traffic(input int cycles, input logic exp_done, input logic exp_err);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         rx_valid = 1'($urandom);
         rx_data  = 8'($urandom);
         #1;
         check("hold_ready",      32'(rx_ready),   32'd0);
         check("hold_done",       32'(done),       32'(exp_done));
         check("hold_error",      32'(error),      32'(exp_err));
         check("hold_core_reset", 32'(core_reset), 32'(exp_done));
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      int n;
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      do_reset();

      // Directed two-word image, back-to-back then gapped
      img[0] = 32'h0000_0513;
      img[1] = 32'h0010_0593;
      load(2, 0, -1);
      random_traffic(10, 1'b1, 1'b0);
      do_reset();
      load(2, 3, -1);

      // Empty image
      do_reset();
      load(0, 0, -1);
      random_traffic(5, 1'b1, 1'b0);

      // Oversize header N=1025
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      @(negedge clk);
      check("ovs_error",      32'(error),      32'd1);
      check("ovs_ready",      32'(rx_ready),   32'd0);
      check("ovs_core_reset", 32'(core_reset), 32'd0);
      random_traffic(50, 1'b0, 1'b1);

      // Reset mid-load after 6 payload bytes, then the full image
      do_reset();
      for (int i = 0; i < 3; i++) img[i] = $urandom;
      load(3, 1, 6);
      do_reset();
      load(3, 1, -1);

      // Randomized images and gaps
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) img[i] = $urandom;
         do_reset();
         load(n, $urandom_range(0, 3), -1);
      end

      // Largest image touches every address once
      for (int i = 0; i < MAXW; i++) img[i] = $urandom;
      do_reset();
      load(MAXW, 0, -1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
